seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_pkg.sv | 31 +++
 rtl/seq_det_core.sv | 65 ++++++
 rtl/seq_det_ctrl.sv | 177 +++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// ----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the two-requester sequence detector controller:
// controller FSM state type, symbol and pattern geometry, match-count width,
// and the saturating counter helper.
// ----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int SYM_W   = 2;               // bits per symbol
    localparam int PAT_LEN = 4;               // symbols per pattern
    localparam int PAT_W   = SYM_W * PAT_LEN; // packed pattern width
    localparam int CNT_W   = 6;               // match counter width

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // Increment by one when inc is set, holding at CNT_MAX.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             inc);
        if (inc && (cnt != CNT_MAX)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// ----------------------------------------------------------------------------
// seq_det_core
// Overlapping 4-symbol pattern matcher. Keeps the last three accepted symbols
// and flags a match one cycle after the symbol that completes PATTERN.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset
//   clear_i  in   synchronous history clear (new burst)
//   valid_i  in   sym_i is accepted this cycle
//   sym_i    in   SYM_W-bit symbol
//   match_o  out  one-cycle pulse, registered
// ----------------------------------------------------------------------------
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter logic [PAT_W-1:0] PATTERN = 8'b11_00_01_10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic             match_o
);

    localparam int              HIST_W   = SYM_W * (PAT_LEN - 1);
    localparam logic [1:0]      FILL_MAX = 2'(PAT_LEN - 1);

    logic [HIST_W-1:0] hist_q, hist_d;
    logic [1:0]        fill_q, fill_d;   // symbols held in history, capped at 3
    logic              match_q, match_d;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (valid_i) begin
            // Fill count guards against matching on stale zeros after a clear.
            match_d = (fill_q == FILL_MAX) && ({hist_q, sym_i} == PATTERN);
            hist_d  = {hist_q[HIST_W-SYM_W-1:0], sym_i};
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign match_o = match_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// ----------------------------------------------------------------------------
// seq_det_ctrl
// Round-robin arbiter between two symbol streams feeding one pattern matcher.
// A granted requester streams symbols until it marks one Last; the controller
// then reports the number of pattern matches seen in that burst.
//
// Optional feature macro: SEQ_DET_CTRL_TIMEOUT_EN
//   defined   -> a stream with TIMEOUT_CYC consecutive cycles without an
//                accepted symbol is ended with Aborted=1
//   undefined -> no timer, Aborted tied low, a stream waits indefinitely
//
// Ports:
//   Clk, Reset               clock (rising edge), async active-high reset
//   ReqN, SymN, SymValidN,   requester N request, symbol, symbol valid,
//   LastN                    final-symbol flag (N = 0, 1)
//   GrantN, SymReadyN        detector owned by N, symbol accepted
//   Done, DoneId             one-cycle burst-complete pulse, its requester
//   Count, Result, Aborted   matches in burst, Count nonzero, timed out
// ----------------------------------------------------------------------------
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned      TIMEOUT_CYC = 16,
    parameter logic [PAT_W-1:0] PATTERN     = 8'b11_00_01_10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0,
    input  logic [SYM_W-1:0] Sym0,
    input  logic             SymValid0,
    input  logic             Last0,
    input  logic             Req1,
    input  logic [SYM_W-1:0] Sym1,
    input  logic             SymValid1,
    input  logic             Last1,
    output logic             Grant0,
    output logic             SymReady0,
    output logic             Grant1,
    output logic             SymReady1,
    output logic             Done,
    output logic             DoneId,
    output logic [CNT_W-1:0] Count,
    output logic             Result,
    output logic             Aborted
);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;   // current / most recent grant holder
    logic             last_q, last_d;     // round-robin pointer: last served
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_sum;
    logic             start_grant;
    logic             win;
    logic             core_clear;
    logic             accept;
    logic             cur_last;
    logic [SYM_W-1:0] cur_sym;
    logic             match;
    logic             timeout_hit;

    assign Grant0    = (state_q == ST_STREAM) && !owner_q;
    assign Grant1    = (state_q == ST_STREAM) &&  owner_q;
    assign SymReady0 = Grant0;
    assign SymReady1 = Grant1;

    assign accept   = (Grant0 && SymValid0) || (Grant1 && SymValid1);
    assign cur_sym  = owner_q ? Sym1  : Sym0;
    assign cur_last = owner_q ? Last1 : Last0;

    assign start_grant = (state_q == ST_IDLE) && (Req0 || Req1);

    // The matcher's pulse lands one cycle after the symbol; folding it in
    // combinationally lets a match completed by the Last symbol show up in
    // Count during the Done cycle.
    assign count_sum = sat_inc(count_q, match);

    seq_det_core #(
        .PATTERN (PATTERN)
    ) u_core (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clear_i (core_clear),
        .valid_i (accept),
        .sym_i   (cur_sym),
        .match_o (match)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        count_d    = count_sum;
        core_clear = 1'b0;
        // On a tie the requester not served last wins.
        win        = (Req0 && Req1) ? ~last_q : Req1;
        unique case (state_q)
            ST_IDLE: begin
                if (start_grant) begin
                    state_d    = ST_STREAM;
                    owner_d    = win;
                    last_d     = win;
                    count_d    = '0;
                    core_clear = 1'b1;
                end
            end
            ST_STREAM: begin
                if ((accept && cur_last) || timeout_hit) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;   // requester 0 wins the first tie
            count_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] idle_q, idle_d;   // consecutive cycles without accept
    logic             aborted_q, aborted_d;

    assign timeout_hit = (state_q == ST_STREAM) && !accept && (idle_q == TMR_LAST);

    always_comb begin
        idle_d    = idle_q;
        aborted_d = aborted_q;
        if ((state_q != ST_STREAM) || accept) begin
            idle_d = '0;
        end else if (!timeout_hit) begin
            idle_d = idle_q + 1'b1;
        end
        if (start_grant) begin
            aborted_d = 1'b0;
        end else if (timeout_hit) begin
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idle_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            aborted_q <= aborted_d;
        end
    end

    assign Aborted = aborted_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
    assign Aborted            = 1'b0;
`endif

    assign Done   = (state_q == ST_REPORT);
    assign DoneId = owner_q;
    assign Count  = count_sum;
    assign Result = |count_sum;

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;

    localparam logic [7:0] PAT = 8'b11_00_01_10;
    localparam int         TO  = 16;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       req  [2];
    logic [1:0] sym  [2];
    logic       sv   [2];
    logic       last [2];
    logic       g0, g1, r0, r1, done, done_id, result, aborted;
    logic [5:0] count;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         last_served;          // model round-robin pointer
    logic [1:0] stim_q[$];            // symbols of the burst being driven
    logic [1:0] pat_sym[4];

    always #5 Clk = ~Clk;

    seq_det_ctrl #(.TIMEOUT_CYC(TO), .PATTERN(PAT)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req0      (req[0]),
        .Sym0      (sym[0]),
        .SymValid0 (sv[0]),
        .Last0     (last[0]),
        .Req1      (req[1]),
        .Sym1      (sym[1]),
        .SymValid1 (sv[1]),
        .Last1     (last[1]),
        .Grant0    (g0),
        .SymReady0 (r0),
        .Grant1    (g1),
        .SymReady1 (r1),
        .Done      (done),
        .DoneId    (done_id),
        .Count     (count),
        .Result    (result),
        .Aborted   (aborted)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: count every (overlapping) window equal to the pattern, cap at 63.
    function automatic int model_matches();
        int c = 0;
        for (int i = 3; i < stim_q.size(); i++) begin
            if (stim_q[i-3] == pat_sym[0] && stim_q[i-2] == pat_sym[1] &&
                stim_q[i-1] == pat_sym[2] && stim_q[i]   == pat_sym[3])
                c++;
        end
        return (c > 63) ? 63 : c;
    endfunction

    task automatic fill_rich(input int len);
        stim_q.delete();
        while (stim_q.size() < len) begin
            if ($urandom_range(1) == 1)
                for (int k = 0; k < 4; k++) stim_q.push_back(pat_sym[k]);
            else
                stim_q.push_back(2'($urandom_range(3)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_g0"},     32'(g0),      0);
        check_val({tag, "_g1"},     32'(g1),      0);
        check_val({tag, "_r0"},     32'(r0),      0);
        check_val({tag, "_r1"},     32'(r1),      0);
        check_val({tag, "_done"},   32'(done),    0);
        check_val({tag, "_doneid"}, 32'(done_id), 0);
        check_val({tag, "_count"},  32'(count),   0);
        check_val({tag, "_result"}, 32'(result),  0);
        check_val({tag, "_abort"},  32'(aborted), 0);
    endtask

    // Drives stim_q as one burst on requester n; called at a negedge in IDLE
    // (or in REPORT's following IDLE cycle), with the grant expected one cycle later.
    task automatic do_burst(input int n, input int max_gap, input bit drop_req);
        int exp_c;
        int other;
        other  = 1 - n;
        req[n] = 1'b1;
        @(negedge Clk);
        last_served = n;
        check_val("grant_latency",   32'(n ? g1 : g0), 1);
        check_val("other_grant_low", 32'(n ? g0 : g1), 0);
        if (drop_req && $urandom_range(1) == 1) req[n] = 1'b0;
        for (int i = 0; i < stim_q.size(); i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
            for (int k = 0; k < gap; k++) begin
                sv[n]       = 1'b0;
                sym[n]      = 2'($urandom);
                last[n]     = 1'($urandom);
                sv[other]   = 1'($urandom);
                sym[other]  = 2'($urandom);
                last[other] = 1'($urandom);
                @(negedge Clk);
                check_val("grant_hold", 32'(n ? g1 : g0), 1);
                check_val("done_low",   32'(done), 0);
            end
            sv[n]       = 1'b1;
            sym[n]      = stim_q[i];
            last[n]     = (i == stim_q.size() - 1);
            sv[other]   = 1'($urandom);
            sym[other]  = 2'($urandom);
            last[other] = 1'($urandom);
            check_val("ready_owner", 32'(n ? r1 : r0), 1);
            check_val("ready_other", 32'(n ? r0 : r1), 0);
            @(negedge Clk);
        end
        sv[0] = 1'b0; sv[1] = 1'b0; last[0] = 1'b0; last[1] = 1'b0;
        req[n] = 1'b0;
        exp_c  = model_matches();
        check_val("done_pulse",  32'(done),    1);
        check_val("done_id",     32'(done_id), 32'(n));
        check_val("count",       32'(count),   32'(exp_c));
        check_val("result",      32'(result),  32'(exp_c != 0));
        check_val("aborted_low", 32'(aborted), 0);
        check_val("grant_drop",  32'(n ? g1 : g0), 0);
        @(negedge Clk);
        check_val("done_one_cycle", 32'(done),    0);
        check_val("count_held",     32'(count),   32'(exp_c));
        check_val("done_id_held",   32'(done_id), 32'(n));
    endtask

    // Both requesters raise Req together; the model pointer picks the order.
    task automatic both_bursts(input int len_a, input int len_b);
        int w;
        w = (last_served == 0) ? 1 : 0;
        req[0] = 1'b1; req[1] = 1'b1;
        fill_rich(len_a);
        do_burst(w, 3, 1'b0);
        fill_rich(len_b);
        do_burst(1 - w, 3, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] p;
        int waited;
        bit saw_done;
        p = PAT;
        for (int k = 0; k < 4; k++) pat_sym[k] = p[7-2*k -: 2];
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; sym[k] = 2'b00; sv[k] = 1'b0; last[k] = 1'b0;
        end
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check_all_zero("reset");
        Reset = 1'b0;
        last_served = 1;
        @(negedge Clk);
        check_all_zero("idle_after_reset");

        // Simultaneous requests right after reset: 0 first, then 1.
        req[0] = 1'b1; req[1] = 1'b1;
        stim_q = '{2'b11, 2'b00, 2'b01, 2'b10};
        check_val("rr_first_winner", 32'((last_served == 0) ? 1 : 0), 0);
        do_burst(0, 0, 1'b0);
        stim_q = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
        do_burst(1, 1, 1'b0);

        // Single-requester bursts: no match, then saturation.
        stim_q = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        do_burst(0, 2, 1'b1);
        stim_q.delete();
        for (int r = 0; r < 300; r++)
            for (int k = 0; k < 4; k++) stim_q.push_back(pat_sym[k]);
        do_burst(1, 0, 1'b1);

        // Stalled stream after two symbols.
        req[0] = 1'b1;
        @(negedge Clk);
        last_served = 0;
        check_val("to_grant", 32'(g0), 1);
        req[0] = 1'b0;
        sv[0] = 1'b1; sym[0] = 2'b11; last[0] = 1'b0;
        @(negedge Clk);
        sym[0] = 2'b00;
        @(negedge Clk);
        sv[0] = 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        waited = 0;
        while (!done && waited < 40) begin
            @(negedge Clk);
            waited++;
        end
        check_val("to_cycles",  32'(waited),  32'(TO));
        check_val("to_done",    32'(done),    1);
        check_val("to_aborted", 32'(aborted), 1);
        check_val("to_count",   32'(count),   0);
        check_val("to_result",  32'(result),  0);
        check_val("to_doneid",  32'(done_id), 0);
        @(negedge Clk);
        check_val("to_aborted_held", 32'(aborted), 1);
`else
        saw_done = 1'b0;
        waited   = 0;
        repeat (40) begin
            @(negedge Clk);
            if (done) saw_done = 1'b1;
        end
        check_val("no_to_done",  32'(saw_done), 0);
        check_val("no_to_grant", 32'(g0), 1);
        sv[0] = 1'b1; sym[0] = 2'b01; last[0] = 1'b1;
        @(negedge Clk);
        sv[0] = 1'b0; last[0] = 1'b0;
        check_val("no_to_late_done", 32'(done),    1);
        check_val("no_to_count",     32'(count),   0);
        check_val("no_to_aborted",   32'(aborted), 0);
        @(negedge Clk);
`endif

        // Reset in the middle of a burst that already holds one match.
        req[0] = 1'b1;
        @(negedge Clk);
        check_val("mid_grant", 32'(g0), 1);
        for (int k = 0; k < 4; k++) begin
            sv[0] = 1'b1; sym[0] = pat_sym[k]; last[0] = 1'b0;
            @(negedge Clk);
        end
        sv[0] = 1'b1; sym[0] = 2'b11;
        check_val("mid_count_before", 32'(count), 1);
        #2 Reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge Clk);
        Reset = 1'b0; req[0] = 1'b0; sv[0] = 1'b0;
        last_served = 1;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            if (done) saw_done = 1'b1;
        end
        check_val("reset_no_done", 32'(saw_done), 0);
        both_bursts(6, 9);
        stim_q = '{2'b11, 2'b00, 2'b01, 2'b10};
        do_burst(0, 0, 1'b0);

        // Randomized bursts.
        for (int it = 0; it < 25; it++) begin
            int mode;
            mode = int'($urandom_range(2));
            repeat ($urandom_range(2)) @(negedge Clk);
            if (mode == 2) begin
                both_bursts(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)));
            end else begin
                fill_rich(int'($urandom_range(1, 24)));
                do_burst(mode, 3, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
